// File: rtl/uart_int_pkg.sv
// Shared constants for the UART interrupt controller: source IDs, FSM encoding, ISR layout.
package uart_int_pkg;

    localparam logic [2:0] ID_NONE = 3'd0;
    localparam logic [2:0] ID_TFE  = 3'd1;
    localparam logic [2:0] ID_THE  = 3'd2;
    localparam logic [2:0] ID_RDA  = 3'd3;
    localparam logic [2:0] ID_RTO  = 3'd4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CLR  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam int unsigned ISR_FLAG_LSB = 0;
    localparam int unsigned ISR_ID_LSB   = 4;
    localparam int unsigned ISR_IRQ_BIT  = 7;

endpackage

// File: rtl/uart_int_prio.sv
// Combinational priority encoder for pending interrupt sources: RTO > RDA > THE > TFE.
module uart_int_prio
    import uart_int_pkg::*;
(
    input  logic [3:0] pend_i,
    output logic [2:0] id_o
);

    always_comb begin
        id_o = ID_NONE;
        if (pend_i[3]) begin
            id_o = ID_RTO;
        end else if (pend_i[2]) begin
            id_o = ID_RDA;
        end else if (pend_i[1]) begin
            id_o = ID_THE;
        end else if (pend_i[0]) begin
            id_o = ID_TFE;
        end
    end

endmodule

// File: rtl/uart_int_ctrl.sv
// UART host interrupt controller: enable mask, registered IRQ, read-to-clear handshake.
// Optional IRQ coalescing is built when UART_INT_COALESCE_EN is defined.
module uart_int_ctrl
    import uart_int_pkg::*;
#(
    parameter int unsigned pHoldoff  = 4,
    parameter int unsigned pCoalesce = 16
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       iTFE,
    input  logic       iTHE,
    input  logic       iRDA,
    input  logic       iRTO,
    input  logic       WE_IER,
    input  logic [3:0] DI,
    input  logic       RE_ISR,
    output logic [7:0] DO,
    output logic [3:0] IER,
    output logic       Clr_Int,
    output logic       IRQ,
    output logic       Busy
);

    localparam logic [3:0] HoldLoad = 4'(pHoldoff - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] hold_q, hold_d;
    logic [3:0] ier_q, ier_d;
    logic [7:0] do_q, do_d;
    logic       irq_q, irq_d;

    logic [3:0] flags;
    logic [3:0] pend;
    logic [2:0] id;

    assign flags = {iRTO, iRDA, iTHE, iTFE};
    assign pend  = flags & ier_q;

    uart_int_prio u_prio (
        .pend_i (pend),
        .id_o   (id)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        do_d    = do_q;
        ier_d   = WE_IER ? DI : ier_q;
        unique case (state_q)
            ST_IDLE: begin
                if (RE_ISR) begin
                    do_d[ISR_IRQ_BIT]       = irq_q;
                    do_d[ISR_ID_LSB +: 3]   = id;
                    do_d[ISR_FLAG_LSB +: 4] = flags;
                    state_d                 = ST_CLR;
                end
            end
            ST_CLR: begin
                hold_d  = HoldLoad;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (hold_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef UART_INT_COALESCE_EN
    localparam logic [7:0] CoalLast = 8'(pCoalesce - 1);

    logic [7:0] coal_q, coal_d;
    logic       low_pend;
    logic       stay_idle;

    // RTO bypasses the qualification window; only the lower sources are coalesced.
    assign low_pend  = |pend[2:0];
    assign stay_idle = (state_q == ST_IDLE) && (state_d == ST_IDLE);

    always_comb begin
        coal_d = coal_q;
        if (!stay_idle || (pend == 4'd0)) begin
            coal_d = 8'd0;
        end else if (low_pend && (coal_q != 8'hFF)) begin
            coal_d = coal_q + 8'd1;
        end
        irq_d = (state_d == ST_IDLE) && (pend[3] || (low_pend && (coal_q >= CoalLast)));
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            coal_q <= 8'd0;
        end else begin
            coal_q <= coal_d;
        end
    end
`else
    // Looking at the next state keeps IRQ low on the very cycle the FSM enters CLR.
    always_comb begin
        irq_d = (|pend) && (state_d == ST_IDLE);
    end
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            hold_q  <= 4'd0;
            ier_q   <= 4'd0;
            do_q    <= 8'd0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            ier_q   <= ier_d;
            do_q    <= do_d;
            irq_q   <= irq_d;
        end
    end

    assign DO      = do_q;
    assign IER     = ier_q;
    assign IRQ     = irq_q;
    assign Clr_Int = (state_q == ST_CLR);
    assign Busy    = (state_q != ST_IDLE);

endmodule
